dec_3to8_strobe: RTL and testbench



---
 rtl/dec_3to8_strobe.sv | 111 +++++++++++
 tb/tb_dec_3to8_strobe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dec_3to8_strobe.sv
// rtl/dec_3to8_strobe.sv - sequenced 3-to-8 one-hot strobe decoder with programmable pulse and gap
// Optional sticky busy-drop flag ERR_O enabled by defining DEC_3TO8_ERR_EN.
module dec_3to8_strobe #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] ARR_I,
  input  logic       VALID_I,
  output logic       READY_O,
  output logic [7:0] ARR_O,
  output logic       VALID_O
`ifdef DEC_3TO8_ERR_EN
  ,
  output logic       ERR_O
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic [7:0] arr_q, arr_d;
  logic       valid_q, valid_d;

  assign READY_O = (state_q == ST_IDLE);
  assign ARR_O   = arr_q;
  assign VALID_O = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (VALID_I) begin
          code_d  = ARR_I;
          cnt_d   = PULSE_M1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          if (GAP_LEN == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = GAP_M1;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are computed from the next state so they register in the same edge as the transition.
    arr_d   = (state_d == ST_PULSE) ? (8'b1 << code_d) : 8'h00;
    valid_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      code_q  <= 3'd0;
      arr_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      arr_q   <= arr_d;
      valid_q <= valid_d;
    end
  end

`ifdef DEC_3TO8_ERR_EN
  logic err_q, err_d;

  assign ERR_O = err_q;

  always_comb begin
    err_d = err_q | (VALID_I & ~READY_O);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_dec_3to8_strobe.sv
// tb/tb_dec_3to8_strobe.sv - directed table-driven bench for dec_3to8_strobe
module tb_dec_3to8_strobe;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] code;
    logic [7:0] exp_arr;
    logic       exp_valid;
    logic       exp_ready;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] arr_i = 3'd0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] arr_o;
  logic       valid_o;

  logic [2:0] b_arr_i = 3'd0;
  logic       b_valid_i = 1'b0;
  logic       b_ready_o;
  logic [7:0] b_arr_o;
  logic       b_valid_o;

`ifdef DEC_3TO8_ERR_EN
  logic err_o;
  logic b_err_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dec_3to8_strobe #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut (
    .CLK(clk), .RST(rst), .ARR_I(arr_i), .VALID_I(valid_i),
    .READY_O(ready_o), .ARR_O(arr_o), .VALID_O(valid_o)
`ifdef DEC_3TO8_ERR_EN
    , .ERR_O(err_o)
`endif
  );

  dec_3to8_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut_b (
    .CLK(clk), .RST(rst), .ARR_I(b_arr_i), .VALID_I(b_valid_i),
    .READY_O(b_ready_o), .ARR_O(b_arr_o), .VALID_O(b_valid_o)
`ifdef DEC_3TO8_ERR_EN
    , .ERR_O(b_err_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got arr/valid/ready=%h/%b/%b expected %h/%b/%b",
               name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [2:0] c,
                     input logic [7:0] a, input logic ev, input logic er, input logic ee);
    vec_t t;
    t.rst = r; t.valid = v; t.code = c;
    t.exp_arr = a; t.exp_valid = ev; t.exp_ready = er; t.exp_err = ee;
    vecs.push_back(t);
  endtask

  initial begin
    int t_prev;
    int waited;

    // Reset held two cycles with a code presented: nothing may pulse.
    add(1, 1, 3'd3, 8'h00, 0, 1, 0);
    add(1, 1, 3'd3, 8'h00, 0, 1, 0);
    add(0, 0, 3'd3, 8'h00, 0, 1, 0);
    add(0, 0, 3'd3, 8'h00, 0, 1, 0);
    // Busy input: code 2 accepted, code 6 presented throughout the pulse and gap.
    add(0, 1, 3'd2, 8'h04, 1, 0, 0);
    add(0, 1, 3'd6, 8'h04, 1, 0, 1);
    add(0, 1, 3'd6, 8'h04, 1, 0, 1);
    add(0, 1, 3'd6, 8'h04, 1, 0, 1);
    add(0, 1, 3'd6, 8'h00, 0, 0, 1);
    add(0, 1, 3'd6, 8'h00, 0, 1, 1);
    add(0, 1, 3'd6, 8'h40, 1, 0, 1);
    add(0, 0, 3'd0, 8'h40, 1, 0, 1);
    add(0, 0, 3'd0, 8'h40, 1, 0, 1);
    add(0, 0, 3'd0, 8'h40, 1, 0, 1);
    add(0, 0, 3'd0, 8'h00, 0, 0, 1);
    add(0, 0, 3'd0, 8'h00, 0, 1, 1);
    // Reset on the second pulse cycle: straight back to idle, no gap.
    add(0, 1, 3'd1, 8'h02, 1, 0, 1);
    add(0, 0, 3'd1, 8'h02, 1, 0, 1);
    add(1, 0, 3'd1, 8'h00, 0, 1, 0);
    add(0, 0, 3'd1, 8'h00, 0, 1, 0);
    add(0, 0, 3'd1, 8'h00, 0, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      valid_i = vecs[i].valid;
      arr_i = vecs[i].code;
      tick();
      check($sformatf("vec%0d", i), {arr_o, valid_o, ready_o},
            {vecs[i].exp_arr, vecs[i].exp_valid, vecs[i].exp_ready});
`ifdef DEC_3TO8_ERR_EN
      check_bit($sformatf("vec%0d_err", i), err_o, vecs[i].exp_err);
`endif
    end
    rst = 1'b0;
    valid_i = 1'b0;

    // Full sweep of codes 0..7 honouring READY_O; accepts must be 6 cycles apart.
    t_prev = 0;
    for (int c = 0; c < 8; c++) begin
      waited = 0;
      while (!ready_o && waited < 20) begin
        tick();
        waited++;
      end
      if (!ready_o) begin
        n_vec++;
        n_err++;
        $display("FAIL sweep_ready_timeout code %0d: READY_O still %b", c, ready_o);
      end
      valid_i = 1'b1;
      arr_i = 3'(c);
      tick();
      valid_i = 1'b0;
      if (c > 0) begin
        n_vec++;
        if (cyc - t_prev != 6) begin
          n_err++;
          $display("FAIL sweep_spacing code %0d: got %0d expected 6", c, cyc - t_prev);
        end
      end
      t_prev = cyc;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("sweep_c%0d_p%0d", c, k), {arr_o, valid_o, ready_o},
              {8'h01 << c, 1'b1, 1'b0});
        tick();
      end
      check($sformatf("sweep_c%0d_gap", c), {arr_o, valid_o, ready_o}, {8'h00, 1'b0, 1'b0});
    end
    tick();
    check("sweep_end_idle", {arr_o, valid_o, ready_o}, {8'h00, 1'b0, 1'b1});

    // PULSE_LEN=1, GAP_LEN=0 with code 5 held: one-cycle pulse every other cycle.
    b_valid_i = 1'b1;
    b_arr_i = 3'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("short_pulse%0d", k), {b_arr_o, b_valid_o, b_ready_o}, {8'h20, 1'b1, 1'b0});
      tick();
      check($sformatf("short_idle%0d", k), {b_arr_o, b_valid_o, b_ready_o}, {8'h00, 1'b0, 1'b1});
    end
    b_valid_i = 1'b0;
`ifdef DEC_3TO8_ERR_EN
    check_bit("short_err_sticky", b_err_o, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
